universal_shift_reg: RTL and testbench
======================================

Name: universal_shift_reg

Overview:
Parametrised successor to the team's PIPO register. Adds the following to plain parallel load:
- shift right, shift left, clear and (optionally) rotate modes;
- serial in and serial out pins;
- a self-timed serializer: one start pulse loads d, then shifts it out LSB-first while busy is high, followed by a done pulse.

It sits between parallel data sources and 1-bit serial links or test pins.

Parameters:
WIDTH, 4, register width in bits; must be >= 2; the serializer counter is $clog2(WIDTH) bits.

Ports:
clk     input   1      rising-edge clock
rst     input   1      asynchronous reset, active-low (0 = reset)
en      input   1      enables mode operations in IDLE
mode    input   3      operation select (see Behaviour)
d       input   WIDTH  parallel load data
sin_r   input   1      serial in for right shift/serializer, enters q[WIDTH-1]
sin_l   input   1      serial in for left shift, enters q[0]
start   input   1      serializer start request (sampled in IDLE only)
q       output  WIDTH  register contents
sout_r  output  1      always q[0]
sout_l  output  1      always q[WIDTH-1]
busy    output  1      1 while the serializer is in SHIFT
done    output  1      1-cycle pulse after the serializer finishes

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - q=0, so sout_r=0 and sout_l=0.
  - State=IDLE, cnt=0, busy=0, done=0.
  - Takes effect immediately, including mid-serialization; the operation is abandoned, not resumed.
- FSM states: IDLE, SHIFT, DONE. busy=(state==SHIFT) and done=(state==DONE), both registered.
- IDLE priority 1, start=1 (en is ignored):
  - q<=d, cnt<=0, next state SHIFT.
- IDLE priority 2, start=0 and en=1, decoded by mode:
  - 000 hold.
  - 001 shift right: q<={sin_r, q[WIDTH-1:1]}.
  - 010 shift left: q<={q[WIDTH-2:0], sin_l}.
  - 011 parallel load: q<=d.
  - 100 clear: q<=0.
  - 101 rotate right: q<={q[0], q[WIDTH-1:1]} (optional feature).
  - 110 rotate left: q<={q[WIDTH-2:0], q[WIDTH-1]} (optional feature).
  - 111 reserved, hold.
- IDLE priority 3, start=0 and en=0: hold.
- SHIFT:
  - Lasts exactly WIDTH cycles.
  - In SHIFT cycle k (k=0..WIDTH-1), sout_r = original d[k].
  - At each edge: if cnt==WIDTH-1, go to DONE with q unchanged; otherwise shift right with sin_r fill and cnt<=cnt+1.
  - mode, en and start are ignored.
- DONE:
  - Lasts one cycle; q holds; next state IDLE.
  - start, en and mode are ignored, so a start asserted in DONE is lost.
  - Earliest restart is the first IDLE cycle.
- End state: after serialization q = d >> (WIDTH-1), with the upper bits filled from sin_r as sampled at each shift edge.
- Latency: start-to-done = WIDTH+1 cycles. A mode operation is visible on q one cycle after the edge that samples it.
- No combinational path from any input to any output.

Optional Feature:
Macro: UREG_ROTATE_EN.
- Defined: modes 101 and 110 perform rotate right and rotate left as specified.
- Undefined: modes 101 and 110 hold q, identical to 000, and no rotate logic is synthesized.
- Serializer and all other modes are unaffected either way.

Test Plan:
- Reset, WIDTH=4: hold rst=0 with random d/mode/start -> q=0000, sout_r=0, sout_l=0, busy=0, done=0. Release rst -> still idle.
- Load and shifts, en=1:
  - mode=011, d=1010 -> q=1010.
  - mode=001, sin_r=1 -> q=1101.
  - mode=010, sin_l=0 -> q=1010.
  - mode=100 -> q=0000.
- Enable gating: q=1010, en=0, mode=011, d=1111 for 3 cycles -> q stays 1010. mode=111 with en=1 -> q stays 1010.
- Serializer: d=1011, sin_r=0, 1-cycle start pulse ->
  - busy=1 for 4 cycles, sout_r sequence 1,1,0,1;
  - then done=1 for 1 cycle with busy=0;
  - final q=0001;
  - a start pulse during busy or done has no effect.
- Reset mid-operation: start with d=1011, assert rst=0 in the 2nd busy cycle -> q=0000, busy=0 immediately. After release, no done pulse and the FSM is in IDLE.
- Rotate: q=1001, mode=101 ->
  - with UREG_ROTATE_EN: q=1100, and mode=110 then returns q=1001;
  - without UREG_ROTATE_EN: q stays 1001.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift / load / clear (optional rotate via UREG_ROTATE_EN)
// plus a self-timed LSB-first serializer that reports busy and a one-cycle done pulse.
module universal_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_LOAD  = 3'b011;
  localparam logic [2:0] MODE_CLEAR = 3'b100;
`ifdef UREG_ROTATE_EN
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ROL   = 3'b110;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Handshake: start is a request sampled only in IDLE; busy is high for exactly
  // WIDTH cycles while q[0] streams the loaded word, then done pulses for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q     <= d;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else if (en) begin
            case (mode)
              MODE_HOLD:  q <= q;
              MODE_SHR:   q <= {sin_r, q[WIDTH-1:1]};
              MODE_SHL:   q <= {q[WIDTH-2:0], sin_l};
              MODE_LOAD:  q <= d;
              MODE_CLEAR: q <= '0;
`ifdef UREG_ROTATE_EN
              MODE_ROR:   q <= {q[0], q[WIDTH-1:1]};
              MODE_ROL:   q <= {q[WIDTH-2:0], q[WIDTH-1]};
`endif
              default:    q <= q;
            endcase
          end
        end
        SHIFT: begin
          // The last bit is already on sout_r, so the final edge leaves q untouched.
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            q   <= {sin_r, q[WIDTH-1:1]};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign sout_r    = q[0];
  assign sout_l    = q[WIDTH-1];
  assign state_dbg = state;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed plan items plus randomized mode/serializer traffic
// checked against an arithmetic reference model. Honors UREG_ROTATE_EN like the design.
module tb_universal_shift_reg;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  d = '0;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  q;
  logic          sout_r, sout_l, busy, done;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
    .start(start), .q(q), .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish by 200000");
    $fatal(1, "timeout");
  end

  // Reference for one IDLE mode operation, written with plain integer arithmetic.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] cur, input logic e,
                                          input logic [2:0] m, input logic [W-1:0] din,
                                          input logic sr, input logic sl);
    int unsigned v, top;
    v   = cur;
    top = 1 << (W - 1);
    if (!e) return cur;
    case (m)
      3'd1: v = (v / 2) + (sr ? top : 0);
      3'd2: v = (v * 2) + (sl ? 1 : 0);
      3'd3: v = din;
      3'd4: v = 0;
`ifdef UREG_ROTATE_EN
      3'd5: v = (v / 2) + ((v % 2) * top);
      3'd6: v = (v * 2) + (v / top);
`endif
      default: v = cur;
    endcase
    return W'(v % (1 << W));
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [W-1:0] exp);
    // kept as driver glue only; comparisons are made inline by callers
  endtask

  task automatic mode_op(input string name, input logic e, input logic [2:0] m,
                         input logic [W-1:0] din, input logic sr, input logic sl);
    logic [W-1:0] exp;
    exp = ref_op(q, e, m, din, sr, sl);
    en = e; mode = m; d = din; sin_r = sr; sin_l = sl; start = 1'b0;
    step();
    n_cmp++;
    if (q !== exp) begin
      n_err++; $display("FAIL %s q: got %b want %b", name, q, exp);
    end
    n_cmp++;
    if ({sout_l, sout_r, busy, done} !== {exp[W-1], exp[0], 1'b0, 1'b0}) begin
      n_err++; $display("FAIL %s pins: got l=%b r=%b busy=%b done=%b want l=%b r=%b 0 0",
                        name, sout_l, sout_r, busy, done, exp[W-1], exp[0]);
    end
  endtask

  // Full serialization with random noise on ignored inputs; expected bits come from a queue.
  task automatic serialize(input string name, input logic [W-1:0] din, input bit noisy);
    logic       exp_q[$];
    logic       fill[$];
    logic [W-1:0] exp_final;
    for (int k = 0; k < W; k++) exp_q.push_back(din[k]);
    d = din; start = 1'b1; en = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
    step();
    start = 1'b0;
    for (int k = 0; k < W; k++) begin
      logic b;
      b = exp_q.pop_front();
      n_cmp++;
      if ({busy, done, sout_r} !== {1'b1, 1'b0, b}) begin
        n_err++; $display("FAIL %s shift%0d: got busy=%b done=%b sout_r=%b want 1 0 %b",
                          name, k, busy, done, sout_r, b);
      end
      sin_r = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k < W - 1) fill.push_back(sin_r);
      if (noisy) begin
        start = 1'($urandom_range(0, 1)); en = 1'($urandom_range(0, 1));
        mode = 3'($urandom_range(0, 7)); d = W'($urandom);
      end
      step();
    end
    exp_final = din >> (W - 1);
    for (int j = 0; j < W - 1; j++) exp_final = exp_final | (W'(fill[j]) << (j + 1));
    n_cmp++;
    if ({busy, done, q} !== {1'b0, 1'b1, exp_final}) begin
      n_err++; $display("FAIL %s done: got busy=%b done=%b q=%b want 0 1 %b",
                        name, busy, done, q, exp_final);
    end
    start = noisy ? 1'b1 : 1'b0; en = 1'b1; mode = 3'b100;
    step();
    start = 1'b0; en = 1'b0;
    n_cmp++;
    if ({busy, done, q} !== {1'b0, 1'b0, exp_final}) begin
      n_err++; $display("FAIL %s idle: got busy=%b done=%b q=%b want 0 0 %b",
                        name, busy, done, q, exp_final);
    end
    step();
    n_cmp++;
    if ({busy, done, q} !== {1'b0, 1'b0, exp_final}) begin
      n_err++; $display("FAIL %s lost_start: got busy=%b done=%b q=%b want 0 0 %b",
                        name, busy, done, q, exp_final);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom); mode = 3'($urandom_range(0, 7)); start = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if ({q, sout_r, sout_l, busy, done} !== {{W{1'b0}}, 4'b0000}) begin
        n_err++; $display("FAIL reset_hold: got q=%b r=%b l=%b busy=%b done=%b want all 0",
                          q, sout_r, sout_l, busy, done);
      end
    end
    start = 1'b0; en = 1'b0;
    rst = 1'b1;
    step();
    n_cmp++;
    if ({q, busy, done} !== {{W{1'b0}}, 2'b00}) begin
      n_err++; $display("FAIL reset_release: got q=%b busy=%b done=%b want 0 0 0", q, busy, done);
    end
  endtask

  task automatic test_load_shift();
    mode_op("load",  1'b1, 3'b011, 4'b1010, 1'b0, 1'b0);
    mode_op("shr",   1'b1, 3'b001, 4'b0000, 1'b1, 1'b0);
    n_cmp++;
    if (q !== 4'b1101) begin n_err++; $display("FAIL shr_plan: got %b want 1101", q); end
    mode_op("shl",   1'b1, 3'b010, 4'b0000, 1'b1, 1'b0);
    n_cmp++;
    if (q !== 4'b1010) begin n_err++; $display("FAIL shl_plan: got %b want 1010", q); end
    mode_op("clear", 1'b1, 3'b100, 4'b1111, 1'b0, 1'b1);
    n_cmp++;
    if (q !== 4'b0000) begin n_err++; $display("FAIL clear_plan: got %b want 0000", q); end
  endtask

  task automatic test_enable_gating();
    mode_op("gate_load", 1'b1, 3'b011, 4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) mode_op("gate_en0", 1'b0, 3'b011, 4'b1111, 1'b1, 1'b1);
    mode_op("reserved", 1'b1, 3'b111, 4'b1111, 1'b1, 1'b1);
    n_cmp++;
    if (q !== 4'b1010) begin n_err++; $display("FAIL gate_plan: got %b want 1010", q); end
  endtask

  task automatic test_serializer();
    serialize("ser_plan", 4'b1011, 1'b0);
    n_cmp++;
    if (q !== 4'b0001) begin n_err++; $display("FAIL ser_final: got %b want 0001", q); end
    serialize("ser_noisy", 4'b0110, 1'b1);
  endtask

  task automatic test_reset_mid();
    d = 4'b1011; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({q, busy, done} !== {4'b0000, 2'b00}) begin
      n_err++; $display("FAIL reset_mid: got q=%b busy=%b done=%b want 0000 0 0", q, busy, done);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      n_cmp++;
      if ({q, busy, done} !== {4'b0000, 2'b00}) begin
        n_err++; $display("FAIL reset_mid_after%0d: got q=%b busy=%b done=%b want 0000 0 0",
                          i, q, busy, done);
      end
    end
  endtask

  task automatic test_rotate();
    mode_op("rot_load", 1'b1, 3'b011, 4'b1001, 1'b0, 1'b0);
    mode_op("ror", 1'b1, 3'b101, 4'b0000, 1'b0, 1'b0);
`ifdef UREG_ROTATE_EN
    n_cmp++;
    if (q !== 4'b1100) begin n_err++; $display("FAIL ror_plan: got %b want 1100", q); end
    mode_op("rol", 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
    n_cmp++;
    if (q !== 4'b1001) begin n_err++; $display("FAIL rol_plan: got %b want 1001", q); end
`else
    n_cmp++;
    if (q !== 4'b1001) begin n_err++; $display("FAIL ror_off: got %b want 1001", q); end
    mode_op("rol_off", 1'b1, 3'b110, 4'b0000, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0)
        serialize("rand_ser", W'($urandom), 1'b1);
      else
        mode_op("rand_op", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_enable_gating();
    test_serializer();
    test_reset_mid();
    test_rotate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
